puf_eval_sequencer: RTL

- Sequences one XOR-PUF evaluation per accepted challenge.
- Drives the 64-bit challenge into the inputNetwork transform (x) and waits for it to settle.
- Latches the transformed challenge (y) onto the arbiter-PUF chains, then fires the trigger pulse.
- Waits for the arbiters to resolve, samples the per-chain bits, and returns the XOR response over a valid/ready handshake.

---
 rtl/puf_eval_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/puf_eval_sequencer.sv
// Purpose: sequences one XOR-PUF evaluation per accepted challenge (settle, arm, fire, evaluate, respond).
// Latency: resp_valid rises NET_CYC+ARM_CYC+1+EVAL_CYC edges after accept (NET_CYC+NREP*(ARM_CYC+1+EVAL_CYC) with voting).
// Backpressure: response held in DONE until resp_ready; chal_ready only in IDLE, so no accept on the handshake cycle.
// Optional feature macro: PUF_MAJORITY_VOTE_EN (repeat ARM/FIRE/EVAL NREP times, majority-vote the XOR bit).
`timescale 1ns/1ps
module puf_eval_sequencer #(
   parameter int CW       = 64,
   parameter int NPUF     = 4,
   parameter int NET_CYC  = 2,
   parameter int ARM_CYC  = 4,
   parameter int EVAL_CYC = 8,
   parameter int NREP     = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            chal_valid,
   output logic            chal_ready,
   input  logic [CW-1:0]   chal_in,
   output logic [CW-1:0]   net_x,
   input  logic [CW-1:0]   net_y,
   output logic [CW-1:0]   puf_chal,
   output logic            puf_trig,
   input  logic [NPUF-1:0] puf_resp,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            resp_bit,
   output logic [NPUF-1:0] resp_raw,
   output logic            busy
);

   localparam int MAXC = (NET_CYC > ARM_CYC) ?
                         ((NET_CYC > EVAL_CYC) ? NET_CYC : EVAL_CYC) :
                         ((ARM_CYC > EVAL_CYC) ? ARM_CYC : EVAL_CYC);
   localparam int CNTW = $clog2(MAXC + 1);

   // Reject configurations the sequencing cannot honour.
   if (NET_CYC < 1 || ARM_CYC < 1 || EVAL_CYC < 1 || NREP < 1 || (NREP % 2) == 0) begin : g_bad_cfg
      $error("puf_eval_sequencer: cycle parameters must be >= 1 and NREP odd");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      ARM    = 3'd2,
      FIRE   = 3'd3,
      EVAL   = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]      net_x_q, net_x_d;
   logic [CW-1:0]      puf_chal_q, puf_chal_d;
   logic               puf_trig_q, puf_trig_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_bit_q, resp_bit_d;
   logic [NPUF-1:0]    resp_raw_q, resp_raw_d;

`ifdef PUF_MAJORITY_VOTE_EN
   localparam int REPW = $clog2(NREP + 1);
   logic [REPW-1:0]    rep_q, rep_d;
   logic [REPW-1:0]    ones_q, ones_d;
   logic [REPW-1:0]    ones_sum;
`endif

   // Next-state, counter and output-register updates for the evaluation sequence.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      net_x_d      = net_x_q;
      puf_chal_d   = puf_chal_q;
      resp_bit_d   = resp_bit_q;
      resp_raw_d   = resp_raw_q;
`ifdef PUF_MAJORITY_VOTE_EN
      rep_d        = rep_q;
      ones_d       = ones_q;
      ones_sum     = ones_q + REPW'(^puf_resp);
`endif
      case (state_q)
         IDLE: begin
            if (chal_valid) begin
               net_x_d = chal_in;
               cnt_d   = '0;
               state_d = SETTLE;
`ifdef PUF_MAJORITY_VOTE_EN
               rep_d   = '0;
               ones_d  = '0;
`endif
            end
         end
         SETTLE: begin
            if (cnt_q == CNTW'(NET_CYC - 1)) begin
               puf_chal_d = net_y;
               cnt_d      = '0;
               state_d    = ARM;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         ARM: begin
            if (cnt_q == CNTW'(ARM_CYC - 1)) begin
               cnt_d   = '0;
               state_d = FIRE;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         FIRE: begin
            cnt_d   = '0;
            state_d = EVAL;
         end
         EVAL: begin
            if (cnt_q == CNTW'(EVAL_CYC - 1)) begin
               cnt_d = '0;
`ifdef PUF_MAJORITY_VOTE_EN
               if (rep_q == REPW'(NREP - 1)) begin
                  resp_raw_d = puf_resp;
                  resp_bit_d = (ones_sum > REPW'(NREP / 2));
                  state_d    = DONE;
               end else begin
                  // Challenge stays on the chains; re-arm for the next repeat.
                  rep_d   = rep_q + REPW'(1);
                  ones_d  = ones_sum;
                  state_d = ARM;
               end
`else
               resp_raw_d = puf_resp;
               resp_bit_d = ^puf_resp;
               state_d    = DONE;
`endif
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // Trigger and valid are registered decodes of the state being entered.
      puf_trig_d   = (state_d == FIRE);
      resp_valid_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         net_x_q      <= '0;
         puf_chal_q   <= '0;
         puf_trig_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_bit_q   <= 1'b0;
         resp_raw_q   <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
         rep_q        <= '0;
         ones_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         net_x_q      <= net_x_d;
         puf_chal_q   <= puf_chal_d;
         puf_trig_q   <= puf_trig_d;
         resp_valid_q <= resp_valid_d;
         resp_bit_q   <= resp_bit_d;
         resp_raw_q   <= resp_raw_d;
`ifdef PUF_MAJORITY_VOTE_EN
         rep_q        <= rep_d;
         ones_q       <= ones_d;
`endif
      end
   end

   // Ready is masked during reset so nothing is offered while the block is being cleared.
   assign chal_ready = (state_q == IDLE) && rst_n;
   assign busy       = (state_q != IDLE);
   assign net_x      = net_x_q;
   assign puf_chal   = puf_chal_q;
   assign puf_trig   = puf_trig_q;
   assign resp_valid = resp_valid_q;
   assign resp_bit   = resp_bit_q;
   assign resp_raw   = resp_raw_q;

endmodule
